// File: rtl/s_decimator_pkg.sv
// Shared constants and helpers for the s_decimator block decimator.
package s_decimator_pkg;

  localparam logic [1:0] MODE_AVG   = 2'd0;
  localparam logic [1:0] MODE_MAX   = 2'd1;
  localparam logic [1:0] MODE_MIN   = 2'd2;
  localparam logic [1:0] MODE_FIRST = 2'd3;

  function automatic int calc_lw(input int log2_max);
    return $clog2(log2_max + 1);
  endfunction

endpackage

// File: rtl/s_decimator_round.sv
// Variable arithmetic shift-right of the block sum with round-half-up toward +inf.
module s_decimator_round
  import s_decimator_pkg::*;
#(
  parameter int WIDTH    = 24,
  parameter int LOG2_MAX = 24,
  parameter int LW       = calc_lw(LOG2_MAX)
) (
  input  logic [WIDTH+LOG2_MAX-1:0] sum,
  input  logic [LW-1:0]             shift,
  output logic [WIDTH-1:0]          result
);

  localparam int AW = WIDTH + LOG2_MAX;
  localparam logic [AW-1:0] ONE = AW'(1);

  logic [AW-1:0] bias;
  logic [AW-1:0] biased;
  logic [AW-1:0] shifted;
  logic          unused_hi;

  // The mean of in-range samples always fits, so the upper bits are plain sign copies.
  always_comb begin
    bias = '0;
    if (shift != '0) bias = ONE << (shift - LW'(1));
    biased  = sum + bias;
    shifted = $signed(biased) >>> shift;
    result  = shifted[WIDTH-1:0];
  end

  assign unused_hi = ^shifted[AW-1:WIDTH];

endmodule

// File: rtl/s_decimator.sv
// Runtime-configurable block decimator: average, max, min or first sample per 2^ratio samples.
module s_decimator
  import s_decimator_pkg::*;
#(
  parameter int WIDTH    = 24,
  parameter int LOG2_MAX = 24,
  parameter int LW       = calc_lw(LOG2_MAX)
) (
  input  logic             Clk,
  input  logic             nReset,
  input  logic             InValid,
  input  logic [WIDTH-1:0] Input,
  input  logic [LW-1:0]    Log2Ratio,
  input  logic [1:0]       Mode,
  input  logic             Restart,
  output logic [WIDTH-1:0] Output,
  output logic             OutValid
);

  localparam int AW = WIDTH + LOG2_MAX;
  localparam logic [LOG2_MAX-1:0] CNT_ONE = LOG2_MAX'(1);

  logic                active_q, active_d;
  logic [LOG2_MAX-1:0] cnt_q, cnt_d;
  logic [LW-1:0]       ratio_q, ratio_d;
  logic [1:0]          mode_q, mode_d;
  logic [AW-1:0]       acc_q, acc_d;
  logic [WIDTH-1:0]    ext_q, ext_d;
  logic [WIDTH-1:0]    out_q, out_d;
  logic                out_valid_q, out_valid_d;

  logic                start;
  logic                last;
  logic [LW-1:0]       ratio_clamp, ratio_eff;
  logic [1:0]          mode_eff;
  logic [LOG2_MAX-1:0] cnt_cur;
  logic [AW-1:0]       acc_new;
  logic [WIDTH-1:0]    ext_new;
  logic [WIDTH-1:0]    round_out;

  // cnt is a down-counter of samples remaining; it is loaded with 2^ratio-1 at block start.
  always_comb begin
    ratio_clamp = (Log2Ratio > LW'(LOG2_MAX)) ? LW'(LOG2_MAX) : Log2Ratio;
    start       = InValid & (~active_q | Restart);
    ratio_eff   = start ? ratio_clamp : ratio_q;
    mode_eff    = start ? Mode : mode_q;
    cnt_cur     = start ? ~({LOG2_MAX{1'b1}} << ratio_clamp) : cnt_q;
    last        = (cnt_cur == '0);
    acc_new     = (start ? '0 : acc_q) + {{LOG2_MAX{Input[WIDTH-1]}}, Input};

    ext_new = ext_q;
    if (start) begin
      ext_new = Input;
    end else begin
      case (mode_eff)
        MODE_MAX: if ($signed(Input) > $signed(ext_q)) ext_new = Input;
        MODE_MIN: if ($signed(Input) < $signed(ext_q)) ext_new = Input;
        default:  ext_new = ext_q;
      endcase
    end
  end

  s_decimator_round #(
    .WIDTH    (WIDTH),
    .LOG2_MAX (LOG2_MAX),
    .LW       (LW)
  ) u_round (
    .sum    (acc_new),
    .shift  (ratio_eff),
    .result (round_out)
  );

  always_comb begin
    active_d    = active_q;
    cnt_d       = cnt_q;
    ratio_d     = ratio_q;
    mode_d      = mode_q;
    acc_d       = acc_q;
    ext_d       = ext_q;
    out_d       = out_q;
    out_valid_d = 1'b0;

    if (InValid) begin
      active_d = 1'b1;
      ratio_d  = ratio_eff;
      mode_d   = mode_eff;
      acc_d    = acc_new;
      ext_d    = ext_new;
      cnt_d    = cnt_cur - CNT_ONE;
      if (last) begin
        active_d    = 1'b0;
        cnt_d       = '0;
        acc_d       = '0;
        out_valid_d = 1'b1;
        out_d       = (mode_eff == MODE_AVG) ? round_out : ext_new;
      end
    end else if (Restart) begin
      active_d = 1'b0;
      cnt_d    = '0;
      acc_d    = '0;
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      active_q    <= 1'b0;
      cnt_q       <= '0;
      ratio_q     <= '0;
      mode_q      <= '0;
      acc_q       <= '0;
      ext_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      active_q    <= active_d;
      cnt_q       <= cnt_d;
      ratio_q     <= ratio_d;
      mode_q      <= mode_d;
      acc_q       <= acc_d;
      ext_q       <= ext_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign Output   = out_q;
  assign OutValid = out_valid_q;

endmodule

// File: tb/tb_s_decimator.sv
// Scoreboard bench for s_decimator: expected results queued at stimulus time, popped on each strobe.
module tb_s_decimator;

  localparam int WIDTH    = 24;
  localparam int LOG2_MAX = 24;
  localparam int LW       = 5;

  logic             Clk;
  logic             nReset;
  logic             InValid;
  logic [WIDTH-1:0] Input;
  logic [LW-1:0]    Log2Ratio;
  logic [1:0]       Mode;
  logic             Restart;
  logic [WIDTH-1:0] Output;
  logic             OutValid;

  logic [WIDTH-1:0] exp_q[$];
  int total;
  int bad;
  int strobes;

  s_decimator #(.WIDTH(WIDTH), .LOG2_MAX(LOG2_MAX)) dut (
    .Clk       (Clk),
    .nReset    (nReset),
    .InValid   (InValid),
    .Input     (Input),
    .Log2Ratio (Log2Ratio),
    .Mode      (Mode),
    .Restart   (Restart),
    .Output    (Output),
    .OutValid  (OutValid)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    logic [WIDTH-1:0] e;
    if (nReset && OutValid) begin
      strobes++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_strobe got=%h expected=none", Output);
      end else begin
        e = exp_q.pop_front();
        if (Output !== e) begin
          bad++;
          $display("FAIL scoreboard got=%h expected=%h", Output, e);
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [WIDTH-1:0] x, input logic rs);
    InValid = v;
    Input   = x;
    Restart = rs;
    @(posedge Clk);
    #1;
    InValid = 1'b0;
    Restart = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge Clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain pending=%0d expected=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    nReset = 1'b0; InValid = 1'b0; Input = '0; Log2Ratio = '0; Mode = 2'd0; Restart = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    total++;
    if (Output !== 24'h0) begin bad++; $display("FAIL reset_output got=%h expected=000000", Output); end
    total++;
    if (OutValid !== 1'b0) begin bad++; $display("FAIL reset_outvalid got=%b expected=0", OutValid); end
    @(negedge Clk) nReset = 1'b1;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_avg();
    Mode = 2'd0; Log2Ratio = 5'd2;
    drive(1, 24'd1, 0);
    drive(1, 24'd2, 0);
    drive(0, 24'd0, 0);
    drive(1, 24'd3, 0);
    total++;
    if (OutValid !== 1'b0) begin bad++; $display("FAIL avg_early_strobe got=%b expected=0", OutValid); end
    exp_q.push_back(24'h000003);
    drive(1, 24'd4, 0);
    total++;
    if (OutValid !== 1'b1) begin bad++; $display("FAIL avg_latency got=%b expected=1", OutValid); end
    wait_drain("avg_pos");

    exp_q.push_back(24'hFFFFFE);
    drive(1, -24'sd1, 0);
    drive(1, -24'sd2, 0);
    drive(1, -24'sd3, 0);
    drive(1, -24'sd4, 0);
    exp_q.push_back(24'h7FFFFF);
    for (int i = 0; i < 4; i++) drive(1, 24'h7FFFFF, 0);
    wait_drain("avg_neg_full");
  endtask

  task automatic test_max_min();
    Log2Ratio = 5'd2;
    Mode = 2'd1;
    exp_q.push_back(24'h000005);
    drive(1, 24'd5, 0);
    Mode = 2'd2;
    drive(1, -24'sd7, 0);
    drive(1, 24'd3, 0);
    drive(1, 24'd0, 0);
    Mode = 2'd2;
    exp_q.push_back(24'hFFFFF9);
    drive(1, 24'd5, 0);
    Mode = 2'd0;
    drive(1, -24'sd7, 0);
    drive(1, 24'd3, 0);
    drive(1, 24'd0, 0);
    wait_drain("max_min");
  endtask

  task automatic test_first();
    Log2Ratio = 5'd2; Mode = 2'd3;
    exp_q.push_back(24'd11);
    drive(1, 24'd11, 0);
    drive(1, -24'sd2, 0);
    drive(1, 24'd5, 0);
    drive(1, 24'd6, 0);
    wait_drain("first");
  endtask

  task automatic test_restart();
    Log2Ratio = 5'd3; Mode = 2'd0;
    drive(1, 24'd100, 0);
    drive(1, 24'd100, 0);
    exp_q.push_back(24'd8);
    drive(1, 24'd8, 1);
    for (int i = 0; i < 7; i++) drive(1, 24'd8, 0);
    wait_drain("restart");
    repeat (3) @(posedge Clk);
    #1;
    total++;
    if (Output !== 24'd8) begin bad++; $display("FAIL restart_hold got=%h expected=000008", Output); end

    Log2Ratio = 5'd2;
    for (int i = 0; i < 3; i++) drive(1, 24'd1, 0);
    exp_q.push_back(24'd9);
    drive(1, 24'd9, 1);
    for (int i = 0; i < 3; i++) drive(1, 24'd9, 0);
    wait_drain("restart_final");
  endtask

  task automatic test_back_to_back();
    Log2Ratio = 5'd0; Mode = 2'd0;
    exp_q.push_back(24'h123456);
    exp_q.push_back(24'hABCDEF);
    drive(1, 24'h123456, 0);
    total++;
    if (OutValid !== 1'b1 || Output !== 24'h123456) begin
      bad++; $display("FAIL ratio0_first got=%b/%h expected=1/123456", OutValid, Output);
    end
    drive(1, 24'hABCDEF, 0);
    total++;
    if (OutValid !== 1'b1 || Output !== 24'hABCDEF) begin
      bad++; $display("FAIL ratio0_second got=%b/%h expected=1/abcdef", OutValid, Output);
    end
    wait_drain("ratio0");
  endtask

  task automatic test_clamp();
    int s0;
    s0 = strobes;
    Log2Ratio = 5'd31; Mode = 2'd0;
    for (int i = 0; i < 100; i++) drive(1, 24'(i), 0);
    drive(0, 24'd0, 1);
    total++;
    if (strobes != s0) begin bad++; $display("FAIL clamp_no_strobe got=%0d expected=%0d", strobes, s0); end
  endtask

  task automatic test_reset_mid();
    Log2Ratio = 5'd2; Mode = 2'd0;
    drive(1, 24'd50, 0);
    drive(1, 24'd50, 0);
    nReset = 1'b0;
    #2;
    total++;
    if (Output !== 24'h0 || OutValid !== 1'b0) begin
      bad++; $display("FAIL reset_mid got=%b/%h expected=0/000000", OutValid, Output);
    end
    @(negedge Clk) nReset = 1'b1;
    @(posedge Clk);
    #1;
    exp_q.push_back(24'd5);
    drive(1, 24'd4, 0);
    drive(1, 24'd4, 0);
    drive(1, 24'd4, 0);
    drive(1, 24'd8, 0);
    wait_drain("reset_mid");
  endtask

  task automatic test_random();
    for (int b = 0; b < 8; b++) begin
      int r, m, n, sx, mx, mn, fs;
      longint sum, bias, res;
      logic [WIDTH-1:0] samp[$];
      logic [WIDTH-1:0] e;
      r = $urandom_range(0, 4);
      m = $urandom_range(0, 3);
      n = 1 << r;
      samp.delete();
      for (int i = 0; i < n; i++) samp.push_back(WIDTH'($urandom));
      sum = 0; fs = $signed(samp[0]); mx = fs; mn = fs;
      foreach (samp[i]) begin
        sx = $signed(samp[i]);
        sum += sx;
        if (sx > mx) mx = sx;
        if (sx < mn) mn = sx;
      end
      bias = (r > 0) ? (longint'(1) << (r - 1)) : 0;
      res = (sum + bias) >>> r;
      case (m)
        0: e = res[WIDTH-1:0];
        1: e = WIDTH'(mx);
        2: e = WIDTH'(mn);
        default: e = WIDTH'(fs);
      endcase
      Log2Ratio = LW'(r);
      Mode = 2'(m);
      for (int i = 0; i < n; i++) begin
        if (i == n - 1) exp_q.push_back(e);
        drive(1, samp[i], 0);
        if ($urandom_range(0, 2) == 0) drive(0, 24'd0, 0);
      end
    end
    wait_drain("random");
  endtask

  initial begin
    total = 0; bad = 0; strobes = 0;
    test_reset();
    test_avg();
    test_max_min();
    test_restart();
    test_back_to_back();
    test_clamp();
    test_first();
    test_reset_mid();
    test_random();
    repeat (3) @(posedge Clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
